// File: rtl/data_bus_responder.sv
// Data-side bus responder: word-addressed data RAM plus a small peripheral set
// (LED register, free-running cycle counter, down-counting timer with IRQ flag,
// and a byte FIFO feeding a valid/ready debug transmit port).
// Read data is returned combinationally; all writes commit on the rising edge.
module data_bus_responder #(
   parameter int RAM_WORDS  = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dataAddr,
   input  logic [31:0] dataOut,
   input  logic        memWrite,
   output logic [31:0] dataIn,
   output logic [7:0]  led,
   output logic        timerIrq,
   output logic [7:0]  dbgData,
   output logic        dbgValid,
   input  logic        dbgReady
);

   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   // Peripheral word addresses (byte address >> 2)
   localparam logic [29:0] W_LED   = 30'h2000_0000;
   localparam logic [29:0] W_CYCLE = 30'h2000_0001;
   localparam logic [29:0] W_TLOAD = 30'h2000_0002;
   localparam logic [29:0] W_TCTRL = 30'h2000_0003;
   localparam logic [29:0] W_DBG   = 30'h2000_0004;

   // Address decode
   logic [29:0]       wordAddr;
   logic              isRam;
   logic [RAM_AW-1:0] ramIdx;
   logic              wrLed, wrTload, wrTctrl, wrDbg;
   logic              unusedAddrBits;

   assign wordAddr       = dataAddr[31:2];
   assign isRam          = ~dataAddr[31];
   assign ramIdx         = dataAddr[RAM_AW+1:2];
   assign wrLed          = memWrite & (wordAddr == W_LED);
   assign wrTload        = memWrite & (wordAddr == W_TLOAD);
   assign wrTctrl        = memWrite & (wordAddr == W_TCTRL);
   assign wrDbg          = memWrite & (wordAddr == W_DBG);
   assign unusedAddrBits = ^dataAddr[1:0];

   // Data RAM
   logic [31:0] ram [RAM_WORDS];

   // RAM write port; contents intentionally survive reset
   always_ff @(posedge clk) begin
      if (memWrite && isRam) ram[ramIdx] <= dataOut;
   end

   // LED register and free-running cycle counter
   logic [7:0]  ledReg;
   logic [31:0] cycleCnt;

   // LED register writes and cycle counting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ledReg   <= 8'h00;
         cycleCnt <= 32'h0;
      end else begin
         if (wrLed) ledReg <= dataOut[7:0];
         cycleCnt <= cycleCnt + 32'd1;
      end
   end

   assign led = ledReg;

   // Timer
   logic [31:0] tload, tcount;
   logic        tEn, tAuto, tIrq;
   logic        tcountZero, tTerminal;

   assign tcountZero = (tcount == 32'h0);
   // A TLOAD write on the same edge overrides the decrement, so no terminal event then
   assign tTerminal  = tEn & (tcount == 32'd1) & ~wrTload;

   // Timer reload/decrement, control bits and sticky interrupt flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tload  <= 32'h0;
         tcount <= 32'h0;
         tEn    <= 1'b0;
         tAuto  <= 1'b0;
         tIrq   <= 1'b0;
      end else begin
         if (wrTload) begin
            tload  <= dataOut;
            tcount <= dataOut;
         end else if (tEn && !tcountZero) begin
            if (tTerminal) tcount <= tAuto ? tload : 32'h0;
            else           tcount <= tcount - 32'd1;
         end
         if (wrTctrl) begin
            tEn   <= dataOut[0];
            tAuto <= dataOut[2];
         end
         // Terminal event beats a same-edge write-1-clear
         if (tTerminal)                   tIrq <= 1'b1;
         else if (wrTctrl && dataOut[1])  tIrq <= 1'b0;
      end
   end

   assign timerIrq = tIrq;

   // Debug TX FIFO
   logic [7:0]       fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] rdPtr, wrPtr;
   logic [CNT_W-1:0] fifoCnt;
   logic             ovf;
   logic             fifoEmpty, fifoFull, pop, pushOk, overflow;

   assign fifoEmpty = (fifoCnt == '0);
   assign fifoFull  = (fifoCnt == FULL_CNT);
   assign pop       = ~fifoEmpty & dbgReady;
   // A push into a full FIFO still lands if a pop frees a slot on the same edge
   assign pushOk    = wrDbg & (~fifoFull | pop);
   assign overflow  = wrDbg & fifoFull & ~pop;

   // FIFO storage; only slots between rdPtr and wrPtr are meaningful
   always_ff @(posedge clk) begin
      if (pushOk) fifoMem[wrPtr] <= dataOut[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdPtr   <= '0;
         wrPtr   <= '0;
         fifoCnt <= '0;
         ovf     <= 1'b0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)    rdPtr <= rdPtr + PTR_W'(1);
         case ({pushOk, pop})
            2'b10:   fifoCnt <= fifoCnt + CNT_W'(1);
            2'b01:   fifoCnt <= fifoCnt - CNT_W'(1);
            default: fifoCnt <= fifoCnt;
         endcase
         // A new overflow beats a same-edge clear request
         ovf <= overflow | (ovf & ~(wrDbg & dataOut[8]));
      end
   end

   assign dbgValid = ~fifoEmpty;
   assign dbgData  = fifoEmpty ? 8'h00 : fifoMem[rdPtr];

   // Combinational read mux
   always_comb begin
      dataIn = 32'h0;
      if (isRam) begin
         dataIn = ram[ramIdx];
      end else begin
         case (wordAddr)
            W_LED:   dataIn = {24'h0, ledReg};
            W_CYCLE: dataIn = cycleCnt;
            W_TLOAD: dataIn = tload;
            W_TCTRL: dataIn = {28'h0, tcountZero, tAuto, tIrq, tEn};
            W_DBG:   dataIn = 32'({ovf, fifoFull, fifoEmpty, fifoCnt[PTR_W-1:0]});
            default: dataIn = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed scenarios plus a
// randomized phase, with a scoreboard of expected read data and TX bytes
// consumed by a monitor on the falling clock edge.
module tb_data_bus_responder;

   localparam int RW = 256;
   localparam int FD = 4;

   localparam logic [31:0] A_LED   = 32'h8000_0000;
   localparam logic [31:0] A_CYCLE = 32'h8000_0004;
   localparam logic [31:0] A_TLOAD = 32'h8000_0008;
   localparam logic [31:0] A_TCTRL = 32'h8000_000C;
   localparam logic [31:0] A_DBG   = 32'h8000_0010;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] dataAddr = 32'h0;
   logic [31:0] dataOut = 32'h0;
   logic        memWrite = 1'b0;
   logic [31:0] dataIn;
   logic [7:0]  led;
   logic        timerIrq;
   logic [7:0]  dbgData;
   logic        dbgValid;
   logic        dbgReady = 1'b0;

   data_bus_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .dataAddr(dataAddr), .dataOut(dataOut),
      .memWrite(memWrite), .dataIn(dataIn), .led(led), .timerIrq(timerIrq),
      .dbgData(dbgData), .dbgValid(dbgValid), .dbgReady(dbgReady)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] mRam [int];
   logic [7:0]  mLed;
   logic [31:0] mCycle, mTload, mCount;
   logic        mEn, mAuto, mIrq, mOvf;
   int          mFifoCnt;

   // Scoreboard queues
   logic [31:0] expRd[$];
   string       expName[$];
   logic [7:0]  txExp[$];
   logic        rdEn = 1'b0;
   int          written[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic modelReset();
      mLed = 8'h0; mCycle = 32'h0; mTload = 32'h0; mCount = 32'h0;
      mEn = 1'b0; mAuto = 1'b0; mIrq = 1'b0; mOvf = 1'b0;
      mFifoCnt = 0;
      txExp.delete();
   endtask

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      int idx;
      if (!a[31]) begin
         idx = int'(a[31:2]) % RW;
         if (mRam.exists(idx)) return mRam[idx];
         return 'x;
      end
      case (a[31:2])
         A_LED[31:2]:   return {24'h0, mLed};
         A_CYCLE[31:2]: return mCycle;
         A_TLOAD[31:2]: return mTload;
         A_TCTRL[31:2]: return {28'h0, mCount == 32'h0, mAuto, mIrq, mEn};
         A_DBG[31:2]:   return {27'h0, mOvf, mFifoCnt == FD, mFifoCnt == 0, 2'(mFifoCnt)};
         default:       return 32'h0;
      endcase
   endfunction

   // Apply the inputs present at a rising edge to the model
   task automatic modelStep();
      logic [29:0] w;
      logic        isP, pop, push, term, ovfSet;
      logic [31:0] nCount;
      w = dataAddr[31:2];
      isP = memWrite && dataAddr[31];
      pop = (mFifoCnt > 0) && dbgReady;
      push = isP && (w == A_DBG[31:2]);
      term = 1'b0;
      nCount = mCount;
      if (isP && w == A_TLOAD[31:2]) nCount = dataOut;
      else if (mEn && mCount != 0) begin
         if (mCount == 1) begin
            term = 1'b1;
            nCount = mAuto ? mTload : 32'h0;
         end else nCount = mCount - 1;
      end
      if (isP && w == A_TLOAD[31:2]) mTload = dataOut;
      if (term) mIrq = 1'b1;
      else if (isP && w == A_TCTRL[31:2] && dataOut[1]) mIrq = 1'b0;
      if (isP && w == A_TCTRL[31:2]) begin
         mEn = dataOut[0];
         mAuto = dataOut[2];
      end
      mCount = nCount;
      if (isP && w == A_LED[31:2]) mLed = dataOut[7:0];
      mCycle = mCycle + 32'd1;
      if (memWrite && !dataAddr[31]) mRam[int'(dataAddr[31:2]) % RW] = dataOut;
      ovfSet = 1'b0;
      if (pop) mFifoCnt--;
      if (push) begin
         if (mFifoCnt < FD) begin
            mFifoCnt++;
            txExp.push_back(dataOut[7:0]);
         end else ovfSet = 1'b1;
      end
      mOvf = ovfSet | (mOvf & !(push && dataOut[8]));
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic access(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic doRd, input string nm);
      dataAddr = a;
      dataOut = d;
      memWrite = we;
      rdEn = doRd;
      if (doRd) begin
         expRd.push_back(modelRead(a));
         expName.push_back(nm);
      end
      tick();
      memWrite = 1'b0;
      rdEn = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      access(a, d, 1'b1, 1'b0, "");
   endtask

   task automatic rd(input logic [31:0] a, input string nm);
      access(a, 32'h0, 1'b0, 1'b1, nm);
   endtask

   // Directed read with a fixed expected value
   task automatic rdExp(input logic [31:0] a, input logic [31:0] e, input string nm);
      dataAddr = a;
      memWrite = 1'b0;
      rdEn = 1'b1;
      expRd.push_back(e);
      expName.push_back(nm);
      tick();
      rdEn = 1'b0;
   endtask

   // Monitor: consumes scoreboard entries whenever the DUT presents data
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      string n;
      if (rst) begin
         if (rdEn) begin
            if (expRd.size() == 0) begin
               checks++; failures++;
               $display("FAIL read_unexpected actual=%h expected=none", dataIn);
            end else begin
               e = expRd.pop_front();
               n = expName.pop_front();
               chk(n, dataIn, e);
            end
         end
         chk("led", {24'h0, led}, {24'h0, mLed});
         chk("timerIrq", {31'h0, timerIrq}, {31'h0, mIrq});
         chk("dbgValid", {31'h0, dbgValid}, {31'h0, mFifoCnt > 0});
         if (dbgValid) begin
            if (txExp.size() == 0) begin
               checks++; failures++;
               $display("FAIL dbgData_unexpected actual=%h expected=none", dbgData);
            end else begin
               chk("dbgData", {24'h0, dbgData}, {24'h0, txExp[0]});
               if (dbgReady) void'(txExp.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] a, b, v;
      logic [7:0]  bytes [4];
      int idx;

      modelReset();
      repeat (3) @(posedge clk);
      #3;
      chk("rst_led", {24'h0, led}, 32'h0);
      chk("rst_timerIrq", {31'h0, timerIrq}, 32'h0);
      chk("rst_dbgValid", {31'h0, dbgValid}, 32'h0);
      chk("rst_dbgData", {24'h0, dbgData}, 32'h0);
      @(posedge clk);
      #2 rst = 1'b1;

      // CYCLE reads 0 in the first cycle after reset release
      rdExp(A_CYCLE, 32'h0, "cycle_first");

      // RAM write, readback, alias and unmapped peripheral
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      rdExp(32'h0000_0010, 32'hDEAD_BEEF, "ram_read");
      rdExp(32'h0000_0410, 32'hDEAD_BEEF, "ram_alias");
      rdExp(32'h8000_0040, 32'h0, "unmapped_read");
      dataAddr = 32'h0000_0010; dataOut = 32'h1234_5678; memWrite = 1'b1; rdEn = 1'b1;
      expRd.push_back(32'hDEAD_BEEF); expName.push_back("ram_same_cycle_old");
      tick();
      memWrite = 1'b0; rdEn = 1'b0;
      rdExp(32'h0000_0010, 32'h1234_5678, "ram_after_write");

      // LED and CYCLE
      wr(A_LED, 32'h0000_01A5);
      chk("led_a5", {24'h0, led}, 32'hA5);
      rdExp(A_LED, 32'hA5, "led_read");
      dataAddr = A_CYCLE;
      @(negedge clk) a = dataIn;
      repeat (10) tick();
      @(negedge clk) b = dataIn;
      chk("cycle_delta", b - a, 32'd10);
      tick();

      // Timer one-shot
      wr(A_TLOAD, 32'd5);
      wr(A_TCTRL, 32'h1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk($sformatf("oneshot_irq_edge%0d", k), {31'h0, timerIrq}, {31'h0, k == 5});
      end
      rdExp(A_TCTRL, 32'hB, "oneshot_tctrl");
      tick(); tick();
      rdExp(A_TCTRL, 32'hB, "oneshot_stays0");
      wr(A_TCTRL, 32'h2);
      chk("oneshot_clear", {31'h0, timerIrq}, 32'h0);

      // Timer auto-reload with a write-1-clear collision
      wr(A_TLOAD, 32'd3);
      wr(A_TCTRL, 32'h5);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("auto_irq_edge%0d", k), {31'h0, timerIrq}, {31'h0, k == 3});
      end
      wr(A_TCTRL, 32'h7);
      chk("auto_clear", {31'h0, timerIrq}, 32'h0);
      tick();
      chk("auto_before_term", {31'h0, timerIrq}, 32'h0);
      wr(A_TCTRL, 32'h7);
      chk("auto_set_wins", {31'h0, timerIrq}, 32'h1);
      wr(A_TCTRL, 32'h2);
      chk("auto_stop_clear", {31'h0, timerIrq}, 32'h0);

      // FIFO fill, overflow and drain
      dbgReady = 1'b0;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
      for (int i = 0; i < 4; i++) wr(A_DBG, {24'h0, bytes[i]});
      wr(A_DBG, 32'h55);
      rdExp(A_DBG, 32'h18, "fifo_full_ovf");
      chk("fifo_head", {24'h0, dbgData}, 32'h11);
      dbgReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("fifo_stream%0d", i), {24'h0, dbgData}, {24'h0, bytes[i]});
         tick();
      end
      chk("fifo_drained", {31'h0, dbgValid}, 32'h0);
      rdExp(A_DBG, 32'h14, "fifo_empty_ovf");
      wr(A_DBG, 32'h100);
      rd(A_DBG, "fifo_ovf_cleared");

      // Randomized phase
      for (int i = 0; i < 400; i++) begin
         dbgReady = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 9))
            0: begin
               idx = $urandom_range(16, RW - 1);
               a = ($urandom & 32'h7FFF_FC00) | (idx << 2);
               written.push_back(idx);
               access(a, $urandom, 1'b1, $urandom_range(0, 1) == 1, "rnd_ram_wr");
            end
            1: begin
               if (written.size() > 0) begin
                  idx = written[$urandom_range(0, written.size() - 1)];
                  a = ($urandom & 32'h7FFF_FC00) | (idx << 2);
                  rd(a, "rnd_ram_rd");
               end else tick();
            end
            2: access(A_LED, $urandom, 1'b1, $urandom_range(0, 1) == 1, "rnd_led");
            3: rd(A_LED + 32'(4 * $urandom_range(0, 4)), "rnd_periph_rd");
            4: begin
               v = $urandom;
               v[8] = ($urandom_range(0, 7) == 0);
               access(A_DBG, v, 1'b1, $urandom_range(0, 1) == 1, "rnd_dbg");
            end
            5: access(A_TLOAD, 32'($urandom_range(0, 6)), 1'b1, 1'b0, "");
            6: access(A_TCTRL, 32'($urandom_range(0, 7)), 1'b1, $urandom_range(0, 1) == 1, "rnd_tctrl");
            7: access(32'h8000_0014 + 32'(4 * $urandom_range(0, 50)), $urandom,
                      $urandom_range(0, 1) == 1, 1'b1, "rnd_unmapped");
            8: access(A_CYCLE, $urandom, 1'b1, 1'b1, "rnd_cycle_wr");
            default: tick();
         endcase
      end

      // Reset mid-run with the timer running and the FIFO holding data
      dbgReady = 1'b0;
      wr(A_TLOAD, 32'd2);
      wr(A_TCTRL, 32'h5);
      wr(A_DBG, 32'h77);
      wr(A_LED, 32'hFF);
      tick();
      chk("pre_rst_irq", {31'h0, timerIrq}, 32'h1);
      chk("pre_rst_valid", {31'h0, dbgValid}, 32'h1);
      #2 rst = 1'b0;
      modelReset();
      #1;
      chk("arst_led", {24'h0, led}, 32'h0);
      chk("arst_timerIrq", {31'h0, timerIrq}, 32'h0);
      chk("arst_dbgValid", {31'h0, dbgValid}, 32'h0);
      chk("arst_dbgData", {24'h0, dbgData}, 32'h0);
      dataAddr = A_TCTRL; #1 chk("arst_tctrl", dataIn, 32'h8);
      dataAddr = A_TLOAD; #1 chk("arst_tload", dataIn, 32'h0);
      dataAddr = A_DBG;   #1 chk("arst_dbg", dataIn, 32'h4);
      dataAddr = A_CYCLE; #1 chk("arst_cycle", dataIn, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      rdExp(32'h0000_0010, 32'h1234_5678, "ram_retained");
      rdExp(A_TCTRL, 32'h8, "post_rst_tctrl");
      tick(); tick();
      chk("scoreboard_drained", 32'(expRd.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Responder end of the CPU data bus: it accepts the pipeline's MEM-stage address, write data and write strobe, and returns read data in the same cycle. The block contains a word-addressed data RAM and a small memory-mapped peripheral set: LED register, free-running cycle counter, down-counting timer with interrupt flag, and a 4-entry byte FIFO feeding a debug transmit port with a valid/ready handshake. It sits between the CPU's data-side ports and the board top level.

## Interface
- RAM_WORDS, 256: data RAM depth in 32-bit words. Power of two, ≤ 2^14.
- FIFO_DEPTH, 4: debug TX FIFO entries. Power of two.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- dataAddr  in  32  byte address from the CPU. Bits [1:0] are ignored.
- dataOut  in  32  write data from the CPU.
- memWrite  in  1  write strobe; the write commits on the rising edge.
- dataIn  out  32  read data returned to the CPU. Combinational from dataAddr and current state.
- led  out  8  LED register.
- timerIrq  out  1  timer interrupt flag (level).
- dbgData  out  8  byte at the FIFO head.
- dbgValid  out  1  FIFO not empty.
- dbgReady  in  1  consumer accepts the byte; a pop occurs when dbgValid & dbgReady at the edge.

## Operation
- Address decode on word address w = dataAddr[31:2]:
  - dataAddr[31] = 0: RAM, index w mod RAM_WORDS. The RAM aliases upward.
  - 0x8000_0000 LED (RW): bits [7:0] drive led; upper bits read 0.
  - 0x8000_0004 CYCLE (RO): 32-bit free-running counter, +1 every cycle, wraps 0xFFFF_FFFF→0. Writes are ignored.
  - 0x8000_0008 TLOAD (RW): a write stores the reload value and also loads the timer count. Reads return the reload value.
  - 0x8000_000C TCTRL: bit0 EN (RW), bit1 IRQ (read; write 1 clears), bit2 AUTO (RW). Bit 3 reads the live timer count == 0.
  - 0x8000_0010 DBG: a write pushes dataOut[7:0]. Reads return {27'b0, OVF, FULL, EMPTY, count[1:0]} for FIFO_DEPTH=4; count is 0–3, and FULL distinguishes 4. Writing the address with bit8 = 1 clears OVF.
  - Any other peripheral address: reads 0, writes have no effect.
- RAM has no reset; contents are X until written. Reads of the RAM are combinational.
- Timer: count is 32 bits.
  - When EN=1 and count≠0, count decrements by 1 per cycle.
  - On the 1→0 transition, IRQ is set. If AUTO=1, count reloads from TLOAD on that same edge, so the period is TLOAD cycles. If AUTO=0, the count stays at 0.
  - EN=0 freezes the count.
  - If TLOAD is 0 with AUTO set, the timer does not run.
- Simultaneous events:
  - IRQ set by the terminal event and an IRQ write-1-clear on the same edge: set wins.
  - TLOAD write and decrement on the same edge: the write wins.
- FIFO:
  - A push while full with no pop: the byte is dropped and OVF is set (sticky).
  - A push while full together with a pop: both happen and OVF is unchanged.
  - A push while empty: dbgValid rises the next cycle.
  - dbgData is stable while dbgValid & !dbgReady.
- timerIrq = IRQ.

## Timing
- Reset values (asserted asynchronously while rst=0): led=0, CYCLE=0, TLOAD=0, count=0, EN=0, AUTO=0, IRQ=0, FIFO empty, OVF=0.
  - Resulting outputs: dbgValid=0, dbgData=0, timerIrq=0.
- dataIn is a zero-latency combinational read. A read of an address written in the same cycle returns the old value.
- Register writes are visible on dataIn the cycle after the write edge.
- CYCLE reads N in the N-th cycle after reset release (the first cycle reads 0).
- Reset asserted mid-operation discards FIFO contents and stops the timer. RAM contents are retained.

## Test plan
- RAM: write 0xDEADBEEF to 0x0000_0010. A read of 0x10 returns 0xDEADBEEF. A read of 0x0000_0410 (alias with RAM_WORDS=256) returns the same. A read of 0x8000_0040 returns 0.
- LED and CYCLE: write 0x1A5 to 0x8000_0000 → led=0xA5 and the read returns 0xA5. Two CYCLE reads 10 cycles apart differ by exactly 10. Forcing CYCLE to 0xFFFF_FFFF shows it wraps to 0.
- Timer one-shot: TLOAD=5, TCTRL=0x1 → timerIrq rises on the 5th edge after the TCTRL write, and the count then stays 0. Writing 0x2 to TCTRL clears timerIrq the next cycle.
- Timer auto-reload with a collision: TLOAD=3, TCTRL=0x5 → IRQ sets every 3 cycles. A write-1-clear on the terminal edge leaves IRQ=1.
- FIFO: hold dbgReady=0 and push 0x11,0x22,0x33,0x44,0x55 → FULL=1, OVF=1, and 0x55 is dropped. Then raise dbgReady → 0x11,0x22,0x33,0x44 stream out on consecutive cycles and dbgValid falls.
- Reset mid-run: pulse rst low while the timer is running and the FIFO is non-empty → all outputs and registers return to their reset values immediately (asynchronously), and a RAM word written earlier still reads back unchanged.
